rs_param_issue_queue: RTL and testbench
=======================================

// Module: rs_param_issue_queue
// PURPOSE
//  Parametrised reservation station serving one functional unit (ALU, CMP, branch or LD/ST addr).
//  Holds DEPTH instructions from the IQ and snoops NUM_CDB result buses plus the ROB commit port.
//  Wakes up source operands and issues the oldest fully-ready entry to the FU under valid/ready.
//  Adds dispatch-time CDB bypass, age-ordered select, FU backpressure and flush.
// PARAMETERS
//  DEPTH     4   entries held (>=2)
//  NUM_CDB   7   snooped result buses (ALU x5, CMP, LD/ST); ROB commit port is extra
//  ROB_W     4   ROB tag width
//  XLEN      32  operand width
//  OP_W      3   opcode width
//  PAY_W     32  opaque per-entry payload (e.g. br_pc_out), passed through untouched
// PORTS
//  clk          in   1              clock
//  rst          in   1              synchronous, active-high reset
//  flush        in   1              mispredict squash, clears all entries
//  disp_valid   in   1              IQ offers an instruction
//  disp_ready   out  1              entry free; dispatch accepted when disp_valid&&disp_ready
//  disp_op      in   OP_W           opcode
//  disp_dest    in   ROB_W          destination ROB tag
//  disp_pay     in   PAY_W          payload
//  disp_s1_rdy  in   1              src1 value valid
//  disp_s1_val  in   XLEN           src1 value
//  disp_s1_tag  in   ROB_W          src1 producer tag (when !disp_s1_rdy)
//  disp_s2_rdy/disp_s2_val/disp_s2_tag  in  1/XLEN/ROB_W  as src1
//  cdb_valid    in   NUM_CDB        bus k broadcasting
//  cdb_tag      in   NUM_CDB*ROB_W  bus k tag, bus k at [k*ROB_W +: ROB_W]
//  cdb_val      in   NUM_CDB*XLEN   bus k value
//  cmt_valid/cmt_tag/cmt_val  in  1/ROB_W/XLEN  ROB commit broadcast, treated as bus NUM_CDB
//  iss_valid    out  1              ready entry presented to FU
//  iss_ready    in   1              FU accepts; issue fires when iss_valid&&iss_ready
//  iss_op/iss_dest/iss_pay/iss_s1/iss_s2  out  OP_W/ROB_W/PAY_W/XLEN/XLEN  selected entry
//  occupancy    out  $clog2(DEPTH+1)  valid entry count
// BEHAVIOUR
//  Reset: all entry valid bits, age matrix, occupancy cleared; iss_valid=0, iss_* fields=0,
//   disp_ready=1 the cycle after reset deasserts.
//  Dispatch: disp_ready = (occupancy<DEPTH) && !flush; no credit for a same-cycle issue.
//   Writes lowest-index free entry. Becomes older than every valid entry.
//  Dispatch bypass: src not ready but a live bus tag matches it this cycle -> store the bus value
//   as ready.
//  Wakeup: each valid, not-ready src matching a live bus tag captures the value at the edge.
//   Several buses match the same tag: lowest bus index wins (protocol error, must not hang).
//  Ready = valid && s1 rdy && s2 rdy (registered state only). No CDB->issue bypass, so first
//   issue is the cycle after the last operand is captured; min dispatch->issue latency is 1 cycle.
//  Select: combinational. Oldest ready entry by age matrix. iss_* is zero when iss_valid=0.
//   Entry freed at the edge where iss_valid&&iss_ready.
//   iss_ready=0 holds the selection unless an older entry becomes ready.
//  Same entry issuing and being woken in one cycle: the issue wins and the entry is freed.
//  Dispatch + issue in the same cycle: both happen; occupancy unchanged.
//  Full: disp_ready=0; disp_valid is ignored with no state change.
//  Flush: next edge clears all valid bits and occupancy. Dispatch is blocked and issue still
//   presents but is not required to be consumed; flush has priority over issue and dispatch.
//   Reset mid-operation behaves as flush plus output clear.
//  Age matrix: DEPTH x DEPTH bits.
//   On dispatch to entry e: row e = current valid vector; column e cleared in all other rows.
// TESTING
//  1 Reset, dispatch op=3 s1=5 s2=7 both ready, iss_ready=1 -> iss_valid next cycle,
//    iss_s1=5 iss_s2=7, occupancy 1->0.
//  2 Dispatch s1_tag=4 not ready; bus2 tag=4 val=0xAA two cycles later -> captured.
//    Issue the cycle after with iss_s1=0xAA.
//  3 Dispatch s2_tag=9 while bus0 broadcasts tag=9 val=0x55 the same cycle -> stored ready.
//    Issue next cycle with iss_s2=0x55.
//  4 Fill DEPTH entries, dests 1..4, all ready, iss_ready=0 -> disp_ready=0, iss_dest=1 held.
//    Then iss_ready=1 for 4 cycles -> dests 1,2,3,4 issued in order.
//  5 Three entries waiting, assert flush -> occupancy=0, iss_valid=0 next cycle.
//    A later broadcast of their tags causes no issue.
//  6 Full RS: issue and disp_valid in the same cycle -> dispatch refused.
//    Dispatch accepted next cycle; occupancy DEPTH->DEPTH-1->DEPTH.

Source files
------------

// File: rtl/rs_param_issue_queue.sv
// Reservation station for one functional unit: holds DEPTH entries, snoops result buses
// plus the ROB commit port, and issues the oldest fully-ready entry under valid/ready.
module rs_param_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_CDB = 7,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned PAY_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [ROB_W-1:0]           disp_dest,
  input  logic [PAY_W-1:0]           disp_pay,
  input  logic                       disp_s1_rdy,
  input  logic [XLEN-1:0]            disp_s1_val,
  input  logic [ROB_W-1:0]           disp_s1_tag,
  input  logic                       disp_s2_rdy,
  input  logic [XLEN-1:0]            disp_s2_val,
  input  logic [ROB_W-1:0]           disp_s2_tag,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
  input  logic                       cmt_valid,
  input  logic [ROB_W-1:0]           cmt_tag,
  input  logic [XLEN-1:0]            cmt_val,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [ROB_W-1:0]           iss_dest,
  output logic [PAY_W-1:0]           iss_pay,
  output logic [XLEN-1:0]            iss_s1,
  output logic [XLEN-1:0]            iss_s2,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned NB    = NUM_CDB + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid, s1_rdy, s2_rdy;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [ROB_W-1:0] dest_q [DEPTH];
  logic [PAY_W-1:0] pay_q  [DEPTH];
  logic [XLEN-1:0]  s1_val [DEPTH];
  logic [XLEN-1:0]  s2_val [DEPTH];
  logic [ROB_W-1:0] s1_tag [DEPTH];
  logic [ROB_W-1:0] s2_tag [DEPTH];
  // age[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0] age    [DEPTH];

  // Commit port is appended as the highest-numbered bus
  logic [NB-1:0]       bus_v;
  logic [NB*ROB_W-1:0] bus_t;
  logic [NB*XLEN-1:0]  bus_d;
  assign bus_v = {cmt_valid, cdb_valid};
  assign bus_t = {cmt_tag, cdb_tag};
  assign bus_d = {cmt_val, cdb_val};

  // Returns {hit, value}; lowest-numbered matching bus wins
  function automatic logic [XLEN:0] snoop(input logic [ROB_W-1:0] tag,
                                          input logic [NB-1:0] v,
                                          input logic [NB*ROB_W-1:0] t,
                                          input logic [NB*XLEN-1:0] d);
    logic [XLEN:0] r;
    r = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (!r[XLEN] && v[k] && (t[k*ROB_W +: ROB_W] == tag)) r = {1'b1, d[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [XLEN:0]    w1 [DEPTH];
  logic [XLEN:0]    w2 [DEPTH];
  logic [XLEN:0]    b1, b2;
  logic [DEPTH-1:0] rdy, grant;
  logic [IDX_W-1:0] free_idx;
  logic             disp_fire, iss_fire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w1[i]  = snoop(s1_tag[i], bus_v, bus_t, bus_d);
      w2[i]  = snoop(s2_tag[i], bus_v, bus_t, bus_d);
      rdy[i] = valid[i] && s1_rdy[i] && s2_rdy[i];
    end
    b1 = snoop(disp_s1_tag, bus_v, bus_t, bus_d);
    b2 = snoop(disp_s2_tag, bus_v, bus_t, bus_d);
  end

  // Oldest ready entry: ready and no older entry is ready
  always_comb begin
    for (int i = 0; i < DEPTH; i++) grant[i] = rdy[i] && ((age[i] & rdy) == '0);
  end

  always_comb begin
    iss_valid = 1'b0;
    iss_op    = '0;
    iss_dest  = '0;
    iss_pay   = '0;
    iss_s1    = '0;
    iss_s2    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_valid = 1'b1;
        iss_op    = op_q[i];
        iss_dest  = dest_q[i];
        iss_pay   = pay_q[i];
        iss_s1    = s1_val[i];
        iss_s2    = s2_val[i];
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  assign disp_ready = (occupancy < OCC_W'(DEPTH)) && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_fire   = iss_valid && iss_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      valid     <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !s1_rdy[i] && w1[i][XLEN]) begin
          s1_rdy[i] <= 1'b1;
          s1_val[i] <= w1[i][XLEN-1:0];
        end
        if (valid[i] && !s2_rdy[i] && w2[i][XLEN]) begin
          s2_rdy[i] <= 1'b1;
          s2_val[i] <= w2[i][XLEN-1:0];
        end
        if (iss_fire && grant[i]) valid[i] <= 1'b0;
        if (disp_fire && (IDX_W'(i) != free_idx)) age[i][free_idx] <= 1'b0;
      end
      if (disp_fire) begin
        valid[free_idx]  <= 1'b1;
        age[free_idx]    <= valid;
        op_q[free_idx]   <= disp_op;
        dest_q[free_idx] <= disp_dest;
        pay_q[free_idx]  <= disp_pay;
        s1_tag[free_idx] <= disp_s1_tag;
        s2_tag[free_idx] <= disp_s2_tag;
        s1_rdy[free_idx] <= disp_s1_rdy || b1[XLEN];
        s2_rdy[free_idx] <= disp_s2_rdy || b2[XLEN];
        s1_val[free_idx] <= disp_s1_rdy ? disp_s1_val : b1[XLEN-1:0];
        s2_val[free_idx] <= disp_s2_rdy ? disp_s2_val : b2[XLEN-1:0];
      end
      occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(iss_fire);
    end
  end

endmodule

// File: tb/tb_rs_param_issue_queue.sv
// Directed bench for rs_param_issue_queue: dispatch, bypass, wakeup, age select,
// backpressure, full and flush behaviour with hand-computed expectations.
module tb_rs_param_issue_queue;

  logic        clk, rst, flush;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_op;
  logic [3:0]  disp_dest;
  logic [31:0] disp_pay;
  logic        disp_s1_rdy, disp_s2_rdy;
  logic [31:0] disp_s1_val, disp_s2_val;
  logic [3:0]  disp_s1_tag, disp_s2_tag;
  logic [6:0]  cdb_valid;
  logic [27:0] cdb_tag;
  logic [223:0] cdb_val;
  logic        cmt_valid;
  logic [3:0]  cmt_tag;
  logic [31:0] cmt_val;
  logic        iss_valid, iss_ready;
  logic [2:0]  iss_op;
  logic [3:0]  iss_dest;
  logic [31:0] iss_pay, iss_s1, iss_s2;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;

  rs_param_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_dest(disp_dest), .disp_pay(disp_pay),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_val(disp_s1_val), .disp_s1_tag(disp_s1_tag),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_val(disp_s2_val), .disp_s2_tag(disp_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_dest(iss_dest),
    .iss_pay(iss_pay), .iss_s1(iss_s1), .iss_s2(iss_s2), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [3:0] dest, input logic [2:0] op,
                     input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                     input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    disp_valid  = 1'b1;
    disp_dest   = dest;
    disp_op     = op;
    disp_pay    = 32'h1000 + 32'(dest);
    disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
    disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
  endtask

  task automatic bus(input int k, input logic [3:0] t, input logic [31:0] v);
    cdb_valid[k]       = 1'b1;
    cdb_tag[k*4 +: 4]  = t;
    cdb_val[k*32 +: 32] = v;
  endtask

  task automatic clr_bus();
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    cmt_valid = 1'b0; cmt_tag = '0; cmt_val = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iss_ready = 1'b0;
    disp_valid = 1'b0; disp_op = '0; disp_dest = '0; disp_pay = '0;
    disp_s1_rdy = 1'b0; disp_s1_val = '0; disp_s1_tag = '0;
    disp_s2_rdy = 1'b0; disp_s2_val = '0; disp_s2_tag = '0;
    clr_bus();
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_dest", 64'(iss_dest), 64'd0);
    chk("rst_iss_s1", 64'(iss_s1), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);

    // 1: both ready, issue next cycle
    iss_ready = 1'b1;
    put(4'd1, 3'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    #1;
    chk("t1_no_same_cycle_issue", 64'(iss_valid), 64'd0);
    cyc(); disp_valid = 1'b0; #1;
    chk("t1_iss_valid", 64'(iss_valid), 64'd1);
    chk("t1_iss_op", 64'(iss_op), 64'd3);
    chk("t1_iss_s1", 64'(iss_s1), 64'd5);
    chk("t1_iss_s2", 64'(iss_s2), 64'd7);
    chk("t1_iss_pay", 64'(iss_pay), 64'h1001);
    chk("t1_occ1", 64'(occupancy), 64'd1);
    cyc(); #1;
    chk("t1_occ0", 64'(occupancy), 64'd0);
    chk("t1_drained", 64'(iss_valid), 64'd0);

    // 2: wakeup from bus 2 two cycles after dispatch; bus 1 carries a different tag
    put(4'd2, 3'd1, 1'b0, 32'd0, 4'd4, 1'b1, 32'd3, 4'd0);
    cyc(); disp_valid = 1'b0;
    bus(1, 4'd5, 32'hDEAD);
    #1;
    chk("t2_wait0", 64'(iss_valid), 64'd0);
    chk("t2_occ", 64'(occupancy), 64'd1);
    cyc(); clr_bus(); bus(2, 4'd4, 32'hAA); #1;
    chk("t2_no_bypass", 64'(iss_valid), 64'd0);
    cyc(); clr_bus(); #1;
    chk("t2_iss_valid", 64'(iss_valid), 64'd1);
    chk("t2_iss_s1", 64'(iss_s1), 64'hAA);
    chk("t2_iss_dest", 64'(iss_dest), 64'd2);
    cyc(); #1;
    chk("t2_occ0", 64'(occupancy), 64'd0);

    // 3: dispatch-time bypass from bus 0
    put(4'd3, 3'd2, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd9);
    bus(0, 4'd9, 32'h55);
    cyc(); disp_valid = 1'b0; clr_bus(); #1;
    chk("t3_iss_valid", 64'(iss_valid), 64'd1);
    chk("t3_iss_s2", 64'(iss_s2), 64'h55);
    chk("t3_iss_dest", 64'(iss_dest), 64'd3);
    cyc(); #1;
    chk("t3_occ0", 64'(occupancy), 64'd0);

    // 4: fill, backpressure holds oldest, full ignores dispatch, drain in order
    iss_ready = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      put(4'(d), 3'd0, 1'b1, 32'(d * 16), 4'd0, 1'b1, 32'd0, 4'd0);
      cyc();
    end
    put(4'd9, 3'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    #1;
    chk("t4_occ_full", 64'(occupancy), 64'd4);
    chk("t4_disp_ready", 64'(disp_ready), 64'd0);
    chk("t4_hold_dest", 64'(iss_dest), 64'd1);
    cyc(); disp_valid = 1'b0; #1;
    chk("t4_full_ignored", 64'(occupancy), 64'd4);
    chk("t4_hold_dest2", 64'(iss_dest), 64'd1);
    iss_ready = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      #1;
      chk($sformatf("t4_order_%0d", d), 64'(iss_dest), 64'(d));
      cyc();
    end
    #1;
    chk("t4_empty", 64'(occupancy), 64'd0);
    chk("t4_no_phantom", 64'(iss_valid), 64'd0);

    // 5: flush three waiting entries; later broadcasts wake nothing
    for (int d = 0; d < 3; d++) begin
      put(4'(d + 1), 3'd0, 1'b0, 32'd0, 4'(10 + d), 1'b1, 32'd0, 4'd0);
      cyc();
    end
    disp_valid = 1'b0; #1;
    chk("t5_occ3", 64'(occupancy), 64'd3);
    flush = 1'b1;
    put(4'd7, 3'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    #1;
    chk("t5_flush_blocks_disp", 64'(disp_ready), 64'd0);
    cyc(); flush = 1'b0; disp_valid = 1'b0; #1;
    chk("t5_occ0", 64'(occupancy), 64'd0);
    chk("t5_iss_valid", 64'(iss_valid), 64'd0);
    bus(3, 4'd10, 32'h1); bus(4, 4'd11, 32'h2);
    cmt_valid = 1'b1; cmt_tag = 4'd12; cmt_val = 32'h3;
    cyc(); clr_bus(); #1;
    chk("t5_no_issue", 64'(iss_valid), 64'd0);
    chk("t5_still_empty", 64'(occupancy), 64'd0);

    // 6: full, issue with disp_valid same cycle -> refused; accepted next cycle
    iss_ready = 1'b0;
    for (int d = 5; d <= 8; d++) begin
      put(4'(d), 3'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
      cyc();
    end
    put(4'd13, 3'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    iss_ready = 1'b1; #1;
    chk("t6_disp_ready_full", 64'(disp_ready), 64'd0);
    chk("t6_first", 64'(iss_dest), 64'd5);
    cyc(); iss_ready = 1'b0; #1;
    chk("t6_occ3", 64'(occupancy), 64'd3);
    chk("t6_disp_ready_free", 64'(disp_ready), 64'd1);
    cyc(); disp_valid = 1'b0; #1;
    chk("t6_occ4", 64'(occupancy), 64'd4);
    iss_ready = 1'b1;
    chk("t6_order_6", 64'(iss_dest), 64'd6); cyc(); #1;
    chk("t6_order_7", 64'(iss_dest), 64'd7); cyc(); #1;
    chk("t6_order_8", 64'(iss_dest), 64'd8); cyc(); #1;
    chk("t6_order_13", 64'(iss_dest), 64'd13); cyc(); #1;
    chk("t6_empty", 64'(occupancy), 64'd0);

    // 7: two buses with the same tag (lowest wins) and commit-port wakeup
    put(4'd4, 3'd5, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd7);
    cyc(); disp_valid = 1'b0;
    bus(5, 4'd6, 32'h22); bus(1, 4'd6, 32'h11);
    cmt_valid = 1'b1; cmt_tag = 4'd7; cmt_val = 32'h33;
    cyc(); clr_bus(); #1;
    chk("t7_iss_valid", 64'(iss_valid), 64'd1);
    chk("t7_low_bus_wins", 64'(iss_s1), 64'h11);
    chk("t7_commit_wake", 64'(iss_s2), 64'h33);
    cyc(); #1;
    chk("t7_empty", 64'(occupancy), 64'd0);

    // 8: older entry becoming ready overrides a held younger selection
    iss_ready = 1'b0;
    put(4'd1, 3'd0, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0);
    cyc();
    put(4'd2, 3'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    cyc(); disp_valid = 1'b0; #1;
    chk("t8_young_sel", 64'(iss_dest), 64'd2);
    bus(6, 4'd2, 32'h77);
    cyc(); clr_bus(); #1;
    chk("t8_old_sel", 64'(iss_dest), 64'd1);
    chk("t8_old_val", 64'(iss_s1), 64'h77);
    iss_ready = 1'b1;
    cyc(); #1;
    chk("t8_then_young", 64'(iss_dest), 64'd2);
    cyc(); #1;
    chk("t8_empty", 64'(occupancy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
